// File: rtl/incdec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : incdec_unit
//  Purpose  : Parametrised increment / decrement / pass / clear unit with
//             wrap or saturate behaviour, signed or unsigned interpretation,
//             per-result flags and a 2-entry registered output buffer.
//  Ports    :
//    clk        in   system clock, rising edge
//    rst        in   asynchronous reset, active low
//    in_valid   in   request present
//    in_ready   out  unit can accept a request this cycle
//    in_data    in   operand A            [WIDTH]
//    in_step    in   unsigned step        [STEP_W]
//    in_op      in   00 inc, 01 dec, 10 pass, 11 clear
//    in_sat     in   1 = saturate, 0 = wrap
//    in_signed  in   1 = A is two's-complement
//    out_valid  out  result present at buffer head
//    out_ready  in   consumer takes the result
//    out_data   out  result               [WIDTH]
//    out_carry  out  unsigned carry / borrow
//    out_ovf    out  result out of range for the interpretation
//    out_sat    out  saturation applied
//    out_zero   out  out_data == 0
//  Revision : 1.0  initial release
// ============================================================================
module incdec_unit #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STEP_W-1:0] in_step,
  input  logic [1:0]        in_op,
  input  logic              in_sat,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_sat,
  output logic              out_zero
);

  // Entry layout: {carry, ovf, sat, zero, data}
  localparam int c_ew = WIDTH + 4;
  // Signed arithmetic needs two guard bits: a full-width unsigned step can
  // push a sign-extended operand beyond WIDTH+1 bits.
  localparam int c_xw = WIDTH + 2;

  localparam logic [WIDTH-1:0] c_umax = '1;
  localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [c_xw-1:0]  c_smax_x = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic [c_xw-1:0]  c_smin_x = {3'b111, {(WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Arithmetic on the incoming request
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum_u;
  logic [WIDTH:0]   w_dif_u;
  logic [c_xw-1:0]  w_a_s;
  logic [c_xw-1:0]  w_step_x;
  logic [c_xw-1:0]  w_sum_s;
  logic [c_xw-1:0]  w_dif_s;
  logic             w_inc_ovf_s;
  logic             w_dec_ovf_s;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_satf;
  logic             w_zero;
  logic [c_ew-1:0]  w_entry;

  // Unsigned: bit WIDTH is the carry for inc and the borrow for dec, since
  // the magnitude of either result never reaches 2^(WIDTH+1).
  assign w_sum_u  = {1'b0, in_data} + {{(WIDTH+1-STEP_W){1'b0}}, in_step};
  assign w_dif_u  = {1'b0, in_data} - {{(WIDTH+1-STEP_W){1'b0}}, in_step};

  assign w_a_s    = {{2{in_data[WIDTH-1]}}, in_data};
  assign w_step_x = {{(c_xw-STEP_W){1'b0}}, in_step};
  assign w_sum_s  = w_a_s + w_step_x;
  assign w_dif_s  = w_a_s - w_step_x;

  assign w_inc_ovf_s = $signed(w_sum_s) > $signed(c_smax_x);
  assign w_dec_ovf_s = $signed(w_dif_s) < $signed(c_smin_x);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (in_op)
      2'b00: begin
        w_carry = w_sum_u[WIDTH];
        w_ovf   = in_signed ? w_inc_ovf_s : w_sum_u[WIDTH];
        if (in_sat && w_ovf) w_res = in_signed ? c_smax : c_umax;
        else                 w_res = w_sum_u[WIDTH-1:0];
      end
      2'b01: begin
        w_carry = w_dif_u[WIDTH];
        w_ovf   = in_signed ? w_dec_ovf_s : w_dif_u[WIDTH];
        if (in_sat && w_ovf) w_res = in_signed ? c_smin : '0;
        else                 w_res = w_dif_u[WIDTH-1:0];
      end
      2'b10:   w_res = in_data;
      default: w_res = '0;
    endcase
  end

  assign w_satf  = in_sat & w_ovf;
  assign w_zero  = (w_res == '0);
  assign w_entry = {w_carry, w_ovf, w_satf, w_zero, w_res};

  // --------------------------------------------------------------------------
  // 2-entry output FIFO
  // --------------------------------------------------------------------------
  logic            r_rdy_en;   // holds in_ready low until the first edge out of reset
  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [c_ew-1:0] r_mem0;
  logic [c_ew-1:0] r_mem1;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [c_ew-1:0] w_head;

  assign in_ready = r_rdy_en & (r_count != 2'd2);
  assign w_valid  = (r_count != 2'd0);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_valid & out_ready;
  assign w_head   = r_rd_ptr ? r_mem1 : r_mem0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en <= 1'b0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_mem0   <= '0;
      r_mem1   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) begin
        if (r_wr_ptr) r_mem1 <= w_entry;
        else          r_mem0 <= w_entry;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Popped slots keep stale contents, so the outputs are masked when empty.
  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_head[WIDTH-1:0] : '0;
  assign out_carry = w_valid & w_head[WIDTH+3];
  assign out_ovf   = w_valid & w_head[WIDTH+2];
  assign out_sat   = w_valid & w_head[WIDTH+1];
  assign out_zero  = w_valid & w_head[WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_incdec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_incdec_unit
//  Purpose  : Directed self-checking bench for incdec_unit (WIDTH=16,
//             STEP_W=4). Expected flags are packed {carry, ovf, sat, zero}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_incdec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_step;
  logic [1:0]  in_op;
  logic        in_sat;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_ovf;
  logic        out_sat;
  logic        out_zero;

  int total = 0;
  int bad   = 0;

  incdec_unit #(.WIDTH(16), .STEP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_step   (in_step),
    .in_op     (in_op),
    .in_sat    (in_sat),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_sat   (out_sat),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return 32'({out_carry, out_ovf, out_sat, out_zero});
  endfunction

  task automatic drive(input logic [15:0] a, input logic [3:0] st, input logic [1:0] op,
                       input logic sat, input logic sgn);
    in_valid  = 1'b1;
    in_data   = a;
    in_step   = st;
    in_op     = op;
    in_sat    = sat;
    in_signed = sgn;
  endtask

  // One request with out_ready high: result must be at the head one edge later.
  task automatic do_one(input string tag, input logic [15:0] a, input logic [3:0] st,
                        input logic [1:0] op, input logic sat, input logic sgn,
                        input logic [15:0] ed, input logic [3:0] ef);
    drive(a, st, op, sat, sgn);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(ed));
    chk({tag, "_flags"}, flags(),        32'(ef));
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_step = '0; in_op = '0;
    in_sat = 1'b0; in_signed = 1'b0; out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel_ready_after_edge", 32'(in_ready), 32'd1);
    chk("rel_valid", 32'(out_valid), 32'd0);

    // Legacy incrementer equivalence
    do_one("leg_0b", 16'h000B, 4'd1, 2'b00, 1'b0, 1'b0, 16'h000C, 4'b0000);
    do_one("leg_ff", 16'hFFFF, 4'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 4'b1101);
    do_one("leg_0f", 16'h000F, 4'd1, 2'b00, 1'b0, 1'b0, 16'h0010, 4'b0000);

    // Saturation
    do_one("sat_uinc", 16'hFFFE, 4'd5, 2'b00, 1'b1, 1'b0, 16'hFFFF, 4'b1110);
    do_one("sat_sinc", 16'h7FFD, 4'd4, 2'b00, 1'b1, 1'b1, 16'h7FFF, 4'b0110);
    do_one("sat_sdec", 16'h8002, 4'd3, 2'b01, 1'b1, 1'b1, 16'h8000, 4'b0110);

    // Decrement / borrow
    do_one("dec_wrap", 16'h0002, 4'd3, 2'b01, 1'b0, 1'b0, 16'hFFFF, 4'b1100);
    do_one("dec_sat",  16'h0002, 4'd3, 2'b01, 1'b1, 1'b0, 16'h0000, 4'b1111);

    // Boundaries: step 0, signed wrap past max
    do_one("step0_dec", 16'h0000, 4'd0, 2'b01, 1'b1, 1'b0, 16'h0000, 4'b0001);
    do_one("swrap_inc", 16'h7FFF, 4'd1, 2'b00, 1'b0, 1'b1, 16'h8000, 4'b0100);

    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: 3 back-to-back requests with the consumer stalled
    out_ready = 1'b0;
    drive(16'd1, 4'd1, 2'b00, 1'b0, 1'b0);
    tick();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_head1",  32'(out_data), 32'd2);
    in_data = 16'd2;
    tick();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    in_data = 16'd3;
    tick();
    chk("bp_held_ready", 32'(in_ready), 32'd0);
    chk("bp_held_head",  32'(out_data), 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_out3",   32'(out_data), 32'd3);
    chk("bp_ready3", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_out4",   32'(out_data),  32'd4);
    chk("bp_valid4", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop with one entry resident
    out_ready = 1'b0;
    drive(16'h0010, 4'd1, 2'b00, 1'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'(16'h0020 + 16'(i) * 16'h0010);
      tick();
      chk("pp_data",  32'(out_data),  32'(16'h0021 + 16'(i) * 16'h0010));
      chk("pp_ready", 32'(in_ready),  32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("pp_one_left_ready", 32'(in_ready), 32'd1);
    chk("pp_one_left_data",  32'(out_data), 32'h0051);
    out_ready = 1'b1;
    tick();
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Reset with a full buffer
    out_ready = 1'b0;
    drive(16'h0100, 4'd1, 2'b00, 1'b0, 1'b0);
    tick();
    in_data = 16'h0200;
    tick();
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_data",  32'(out_data),  32'd0);
    chk("mid_flags", flags(),        32'd0);
    chk("mid_ready", 32'(in_ready),  32'd0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_edge_ready", 32'(in_ready),  32'd1);
    chk("mid_no_stale",   32'(out_valid), 32'd0);

    // pass / clear
    do_one("pass",   16'h1234, 4'd7, 2'b10, 1'b1, 1'b1, 16'h1234, 4'b0000);
    do_one("pass0",  16'h0000, 4'd3, 2'b10, 1'b0, 1'b0, 16'h0000, 4'b0001);
    do_one("clear",  16'hFFFF, 4'd9, 2'b11, 1'b1, 1'b0, 16'h0000, 4'b0001);
    tick();
    chk("end_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
